rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
// Shares the register file's single write port between in-order writeback (WB) and a multi-cycle
// late unit (LATE: load-miss/mul-div). LATE results queue in a small FIFO while WB owns the port.
// A 32-entry scoreboard tracks registers with outstanding LATE writes and raises a decode hazard.
// Sits between the WB stage / late unit and the register file write port.
// PARAMETERS
// XLEN        32  data width
// FIFO_DEPTH  4   LATE result queue entries (power of 2, >=2)
// STARVE_MAX  8   consecutive cycles a non-empty FIFO may lose to WB before it takes priority
// PORTS
// clk          in   1     clock, rising edge
// Reset        in   1     asynchronous, active-high reset
// wb_valid     in   1     WB write request
// wb_rd        in   5     WB destination register
// wb_data      in   XLEN  WB write data
// wb_ready     out  1     WB accepted this cycle; WB holds wb_* stable while low
// late_valid   in   1     LATE result valid
// late_rd      in   5     LATE destination register
// late_data    in   XLEN  LATE result data
// late_ready   out  1     LATE result accepted this cycle
// sb_set       in   1     decode issues a LATE op writing sb_rd
// sb_rd        in   5     destination of that op
// dec_rs1/rs2/rd        in  5 each  decoding instruction's operands
// dec_rs1_use/rs2_use/rd_use in 1 each  operand actually used
// hazard       out  1     decode must stall (combinational)
// rf_waddr     out  5     write address to register file; 0 = no write
// rf_wdata     out  XLEN  write data to register file
// fifo_count   out  $clog2(FIFO_DEPTH)+1  entries queued (debug)
// BEHAVIOUR
// - Reset: FIFO empty, scoreboard all clear, starve counter 0; rf_waddr=0, rf_wdata=0, hazard=0,
//   wb_ready=1, late_ready=1. Reset mid-operation discards queued results and pending busy bits.
// - rf_waddr/rf_wdata registered: a grant in cycle N appears on the write port in cycle N+1.
// - rd==0 requests are accepted (ready high) but never written; rf_waddr stays 0 for them.
// - Grant priority each cycle (first match wins):
//   1 starve==STARVE_MAX and FIFO non-empty -> FIFO head; wb_ready=0.
//   2 wb_valid -> WB; wb_ready=1.
//   3 FIFO non-empty -> FIFO head popped.
//   4 late_valid and FIFO empty -> LATE bypass (no queueing).
// - wb_ready=1 in every cycle except case 1 (independent of wb_valid).
// - late_ready = !full, or (full and FIFO head is popped this cycle). Accepted LATE result not
//   bypassed is pushed; push+pop in the same cycle keeps count.
// - Starve counter: +1 (saturate at STARVE_MAX) when FIFO non-empty and WB wins; cleared on any
//   FIFO pop or when FIFO empty.
// - Scoreboard busy[31:1] (busy[0] hardwired 0): set next edge on sb_set with sb_rd!=0;
//   cleared next edge when a LATE write to that rd is granted (FIFO pop or bypass).
//   Same-cycle set+clear same reg -> set wins.
// - hazard = (rs1_use & busy[rs1]) | (rs2_use & busy[rs2]) | (rd_use & busy[rd]).
//   No bypass from the in-flight late write: hazard holds through the grant cycle, drops next cycle.
//   rd check prevents WAW between a pending LATE write and a younger WB write.
// - Protocol errors (late result for non-busy rd, push when full) are undefined; bench asserts.
// TESTING
// 1 Reset, then wb_valid, rd=5, data=0xA5 -> cycle+1: rf_waddr=5, rf_wdata=0xA5; idle next: waddr=0.
// 2 Idle FIFO, late_valid rd=7, data=0x11 -> bypass; next cycle waddr=7; fifo_count stays 0.
// 3 wb_valid continuous, late rd=3,4,5,6,9 -> first 4 queued, late_ready=0 on 5th; fifo_count=4.
// 4 FIFO non-empty, wb_valid held 9 cycles -> cycle 9 FIFO wins, wb_ready=0, WB retried next cycle.
// 5 sb_set rd=8; decode rs1=8 used -> hazard=1 until cycle after late write to x8 granted.
// 6 wb_rd=0 and late_rd=0 -> accepted, rf_waddr stays 0; assert Reset with 3 queued -> count 0, busy clear.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the WB stage / late unit / decode and the register-file write arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface rf_write_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;

  logic            late_valid;
  logic [4:0]      late_rd;
  logic [XLEN-1:0] late_data;
  logic            late_ready;

  logic            sb_set;
  logic [4:0]      sb_rd;

  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic            dec_rs1_use;
  logic            dec_rs2_use;
  logic            dec_rd_use;
  logic            hazard;

  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [CW-1:0]   fifo_count;

  modport master (
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output late_valid, late_rd, late_data,
    input  late_ready,
    output sb_set, sb_rd,
    output dec_rs1, dec_rs2, dec_rd, dec_rs1_use, dec_rs2_use, dec_rd_use,
    input  hazard,
    input  rf_waddr, rf_wdata, fifo_count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  late_valid, late_rd, late_data,
    output late_ready,
    input  sb_set, sb_rd,
    input  dec_rs1, dec_rs2, dec_rd, dec_rs1_use, dec_rs2_use, dec_rd_use,
    output hazard,
    output rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB and the late unit, queueing
// late results in a small FIFO and tracking outstanding late writes in a busy scoreboard.
module rf_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic             clk,
  input logic             Reset,
  rf_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_left_q, starve_left_d;
  logic [31:0]     busy_q, busy_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            fifo_empty, fifo_full, starve_hit;
  logic            grant_fifo, grant_wb, grant_byp;
  logic            late_ready, push, pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    head_rd    = fifo_rd_q[rptr_q];
    head_data  = fifo_data_q[rptr_q];
    // Starvation is a down-counter: terminal count zero means WB has won STARVE_MAX times in a row.
    starve_hit = (starve_left_q == '0) && !fifo_empty;

    grant_fifo = !fifo_empty && (starve_hit || !bus.wb_valid);
    grant_wb   = bus.wb_valid && !starve_hit;
    grant_byp  = fifo_empty && !bus.wb_valid && bus.late_valid;

    pop        = grant_fifo;
    late_ready = !fifo_full || pop;
    push       = bus.late_valid && late_ready && !grant_byp;
  end

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    waddr_d = '0;
    wdata_d = '0;
    if (grant_fifo) begin
      waddr_d = head_rd;
      wdata_d = head_data;
    end else if (grant_wb) begin
      waddr_d = bus.wb_rd;
      wdata_d = bus.wb_data;
    end else if (grant_byp) begin
      waddr_d = bus.late_rd;
      wdata_d = bus.late_data;
    end
  end

  always_comb begin
    starve_left_d = starve_left_q;
    if (pop || fifo_empty) starve_left_d = SW'(STARVE_MAX);
    else if (grant_wb && starve_left_q != '0) starve_left_d = starve_left_q - SW'(1);
  end

  // Clear first so that a same-cycle set for the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (grant_fifo) busy_d[head_rd] = 1'b0;
    else if (grant_byp) busy_d[bus.late_rd] = 1'b0;
    if (bus.sb_set) busy_d[bus.sb_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      starve_left_q <= SW'(STARVE_MAX);
      busy_q        <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      starve_left_q <= starve_left_d;
      busy_q        <= busy_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
    end
  end

  // Queue storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= bus.late_rd;
      fifo_data_q[wptr_q] <= bus.late_data;
    end
  end

  assign bus.wb_ready   = !starve_hit;
  assign bus.late_ready = late_ready;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.fifo_count = count_q;
  assign bus.hazard     = (bus.dec_rs1_use && busy_q[bus.dec_rs1])
                        | (bus.dec_rs2_use && busy_q[bus.dec_rs2])
                        | (bus.dec_rd_use  && busy_q[bus.dec_rd]);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: stimulus pushes hand-computed register-file writes into a
// queue, and a monitor pops and compares each write the DUT presents.
module tb_rf_write_arbiter;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic Reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;

  rf_write_arbiter_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

  rf_write_arbiter #(.XLEN(32), .FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    bus.late_valid  = 1'b0;
    bus.late_rd     = '0;
    bus.late_data   = '0;
    bus.sb_set      = 1'b0;
    bus.sb_rd       = '0;
    bus.dec_rs1     = '0;
    bus.dec_rs2     = '0;
    bus.dec_rd      = '0;
    bus.dec_rs1_use = 1'b0;
    bus.dec_rs2_use = 1'b0;
    bus.dec_rd_use  = 1'b0;
  endtask

  task automatic sb_issue(input logic [4:0] rd);
    bus.sb_set = 1'b1;
    bus.sb_rd  = rd;
    step();
    bus.sb_set = 1'b0;
    bus.sb_rd  = '0;
  endtask

  always @(negedge clk) begin
    if (!Reset && bus.rf_waddr != 5'd0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got waddr %0d data %0h, required no write (t=%0t)",
                 bus.rf_waddr, bus.rf_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.rf_waddr), 64'(mon_e.rd));
        chk("wr_data", 64'(bus.rf_wdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_waddr",      64'(bus.rf_waddr),   64'd0);
    chk("rst_wdata",      64'(bus.rf_wdata),   64'd0);
    chk("rst_hazard",     64'(bus.hazard),     64'd0);
    chk("rst_wb_ready",   64'(bus.wb_ready),   64'd1);
    chk("rst_late_ready", 64'(bus.late_ready), 64'd1);
    chk("rst_count",      64'(bus.fifo_count), 64'd0);
    Reset = 1'b0;
    step();

    // Plain WB write, then an idle cycle.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hA5;
    expect_wr(5'd5, 32'hA5);
    #1 chk("t1_wb_ready", 64'(bus.wb_ready), 64'd1);
    step();
    idle_inputs();
    step();
    step();

    // Late bypass with an empty FIFO.
    sb_issue(5'd7);
    bus.late_valid = 1'b1; bus.late_rd = 5'd7; bus.late_data = 32'h11;
    expect_wr(5'd7, 32'h11);
    #1 chk("t2_late_ready", 64'(bus.late_ready), 64'd1);
    step();
    bus.late_valid = 1'b0;
    #1 chk("t2_count", 64'(bus.fifo_count), 64'd0);
    step();

    // Fill the FIFO behind continuous WB traffic, then let starvation force a FIFO grant.
    sb_issue(5'd3); sb_issue(5'd4); sb_issue(5'd5); sb_issue(5'd6); sb_issue(5'd9);
    bus.dec_rs1 = 5'd9; bus.dec_rs1_use = 1'b1;
    #1 chk("t3_hazard_set", 64'(bus.hazard), 64'd1);
    bus.dec_rs1_use = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      bus.wb_valid   = 1'b1;
      bus.wb_rd      = 5'(10 + ((c < 9) ? c : 9));
      bus.wb_data    = 32'h100 + 32'(bus.wb_rd);
      bus.late_valid = (c <= 9);
      bus.late_rd    = (c < 4) ? 5'(3 + c) : 5'd9;
      bus.late_data  = 32'h200 + 32'(bus.late_rd);
      if (c < 9)  expect_wr(bus.wb_rd, bus.wb_data);
      if (c == 9) expect_wr(5'd3, 32'h203);
      if (c == 10) expect_wr(5'd19, 32'h113);
      #1;
      if (c == 4) begin
        chk("t3_late_ready_full", 64'(bus.late_ready), 64'd0);
        chk("t3_count_full",      64'(bus.fifo_count), 64'd4);
      end
      if (c == 8) chk("t4_wb_ready_c8", 64'(bus.wb_ready), 64'd1);
      if (c == 9) begin
        chk("t4_wb_ready_starve", 64'(bus.wb_ready),   64'd0);
        chk("t4_late_ready_pop",  64'(bus.late_ready), 64'd1);
      end
      if (c == 10) begin
        chk("t4_wb_ready_retry", 64'(bus.wb_ready),   64'd1);
        chk("t4_count_pushpop",  64'(bus.fifo_count), 64'd4);
      end
      step();
    end
    idle_inputs();
    expect_wr(5'd4, 32'h204);
    expect_wr(5'd5, 32'h205);
    expect_wr(5'd6, 32'h206);
    expect_wr(5'd9, 32'h209);
    repeat (6) step();
    chk("t4_count_drained", 64'(bus.fifo_count), 64'd0);
    bus.dec_rs1 = 5'd9; bus.dec_rs1_use = 1'b1;
    #1 chk("t4_hazard_cleared", 64'(bus.hazard), 64'd0);
    idle_inputs();

    // Scoreboard hazard on each operand, held through the grant cycle.
    sb_issue(5'd8);
    bus.dec_rs1 = 5'd8;
    #1 chk("t5_rs1_unused", 64'(bus.hazard), 64'd0);
    bus.dec_rs1_use = 1'b1;
    #1 chk("t5_rs1", 64'(bus.hazard), 64'd1);
    bus.dec_rs1_use = 1'b0; bus.dec_rd = 5'd8; bus.dec_rd_use = 1'b1;
    #1 chk("t5_rd", 64'(bus.hazard), 64'd1);
    bus.dec_rd_use = 1'b0; bus.dec_rs2 = 5'd8; bus.dec_rs2_use = 1'b1;
    #1 chk("t5_rs2", 64'(bus.hazard), 64'd1);
    bus.late_valid = 1'b1; bus.late_rd = 5'd8; bus.late_data = 32'h88;
    expect_wr(5'd8, 32'h88);
    #1 chk("t5_grant_cycle", 64'(bus.hazard), 64'd1);
    step();
    bus.late_valid = 1'b0;
    #1 chk("t5_after_grant", 64'(bus.hazard), 64'd0);
    bus.sb_set = 1'b1; bus.sb_rd = 5'd8;
    bus.late_valid = 1'b1; bus.late_rd = 5'd8; bus.late_data = 32'h99;
    expect_wr(5'd8, 32'h99);
    step();
    bus.sb_set = 1'b0; bus.late_valid = 1'b0;
    #1 chk("t5_set_wins", 64'(bus.hazard), 64'd1);
    bus.late_valid = 1'b1; bus.late_rd = 5'd8; bus.late_data = 32'h77;
    expect_wr(5'd8, 32'h77);
    step();
    bus.late_valid = 1'b0;
    #1 chk("t5_cleared_again", 64'(bus.hazard), 64'd0);
    idle_inputs();
    sb_issue(5'd0);
    bus.dec_rs1 = 5'd0; bus.dec_rs1_use = 1'b1;
    #1 chk("t5_x0_never_busy", 64'(bus.hazard), 64'd0);
    idle_inputs();

    // rd=0 requests are accepted but never written.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
    bus.late_valid = 1'b1; bus.late_rd = 5'd0; bus.late_data = 32'hBEEF;
    #1;
    chk("t6_wb_ready_x0",   64'(bus.wb_ready),   64'd1);
    chk("t6_late_ready_x0", 64'(bus.late_ready), 64'd1);
    step();
    idle_inputs();
    step();
    step();
    bus.late_valid = 1'b1; bus.late_rd = 5'd0; bus.late_data = 32'h1234;
    step();
    idle_inputs();
    step();
    chk("t6_count_x0", 64'(bus.fifo_count), 64'd0);

    // Reset with three queued results and pending busy bits.
    sb_issue(5'd20); sb_issue(5'd21); sb_issue(5'd22);
    for (int c = 0; c < 3; c++) begin
      bus.wb_valid   = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
      bus.late_valid = 1'b1; bus.late_rd = 5'(20 + c); bus.late_data = 32'h300 + 32'(c);
      step();
    end
    bus.late_valid = 1'b0;
    bus.dec_rs1 = 5'd20; bus.dec_rs1_use = 1'b1;
    #1;
    chk("t6_count_3",  64'(bus.fifo_count), 64'd3);
    chk("t6_busy_pre", 64'(bus.hazard),     64'd1);
    Reset = 1'b1;
    #1;
    chk("t6_rst_count",  64'(bus.fifo_count), 64'd0);
    chk("t6_rst_hazard", 64'(bus.hazard),     64'd0);
    chk("t6_rst_waddr",  64'(bus.rf_waddr),   64'd0);
    bus.wb_valid = 1'b0;
    step();
    Reset = 1'b0;
    repeat (6) step();
    chk("t6_post_rst_count",  64'(bus.fifo_count), 64'd0);
    chk("t6_post_rst_hazard", 64'(bus.hazard),     64'd0);
    idle_inputs();
    repeat (2) step();
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
